// File: rtl/snn_frame_loader.sv
// Streams a 98-byte image from the UART into the 784x1 input RAM, runs snn_core once, and returns the digit as ASCII. Each byte is written 1..8 cycles after acceptance.
// rx_clr_rdy is only raised in WAIT_BYTE, so the UART holds the byte otherwise. SEND stalls on tx_busy. Optional LOADER_TIMEOUT_EN drops stale partial frames.
module snn_frame_loader #(
   parameter int NUM_BYTES   = 98,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   output logic              rx_clr_rdy,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wdata,
   output logic              core_start,
   input  logic              core_done,
   input  logic [3:0]        core_digit,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic [3:0]        result,
   output logic              frame_err
);

   localparam int BYTE_W = ADDR_W - 3;

   typedef enum logic [2:0] {
      WAIT_BYTE,
      UNPACK,
      START,
      WAIT_DONE,
      SEND
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [BYTE_W-1:0] byte_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic [3:0]        result_q;
   logic              accept;
   logic              last_bit;
   logic              last_byte;
   logic              timeout;

   assign accept    = (state == WAIT_BYTE) && rx_rdy;
   assign last_bit  = (bit_cnt == 3'd7);
   assign last_byte = (byte_cnt == BYTE_W'(NUM_BYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT_BYTE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_BYTE: begin
            if (accept) begin
               state_nxt = UNPACK;
            end
         end
         UNPACK: begin
            if (last_bit) begin
               state_nxt = last_byte ? START : WAIT_BYTE;
            end
         end
         START: begin
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (core_done) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               state_nxt = WAIT_BYTE;
            end
         end
         default: begin
            state_nxt = WAIT_BYTE;
         end
      endcase
   end

   always_comb begin
      rx_clr_rdy = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = 1'b0;
      core_start = 1'b0;
      tx_start   = 1'b0;
      case (state)
         WAIT_BYTE: begin
            rx_clr_rdy = rx_rdy;
         end
         UNPACK: begin
            ram_we    = 1'b1;
            ram_addr  = {byte_cnt, bit_cnt};
            ram_wdata = shreg[bit_cnt];
         end
         START: begin
            core_start = 1'b1;
         end
         SEND: begin
            tx_start = !tx_busy;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= 8'h00;
         bit_cnt <= 3'd0;
      end else if (accept) begin
         shreg   <= rx_data;
         bit_cnt <= 3'd0;
      end else if (state == UNPACK) begin
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // A timed-out partial frame restarts at byte 0; the RAM keeps its stale bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
      end else if (state == UNPACK && last_bit) begin
         byte_cnt <= last_byte ? '0 : byte_cnt + BYTE_W'(1);
      end else if (timeout) begin
         byte_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= 4'h0;
      end else if (state == WAIT_DONE && core_done) begin
         result_q <= core_digit;
      end
   end

   assign result  = result_q;
   assign tx_data = {4'h3, result_q};

`ifdef LOADER_TIMEOUT_EN
   localparam int IDLE_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [IDLE_W-1:0] idle_cnt;
   logic              idle_run;

   assign idle_run = (state == WAIT_BYTE) && (byte_cnt != '0);
   // An arriving byte wins over an expiring counter in the same cycle.
   assign timeout  = idle_run && !rx_rdy && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (accept || timeout) begin
         idle_cnt <= '0;
      end else if (idle_run) begin
         idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYC;
   assign timeout        = 1'b0;
`endif

   assign frame_err = timeout;

endmodule

// File: tb/tb_snn_frame_loader.sv
// Randomised scoreboard bench for snn_frame_loader: per-byte RAM writes and per-frame ASCII results are queued at issue and popped by a negedge monitor.
module tb_snn_frame_loader;
   localparam int NUM_BYTES   = 98;
   localparam int ADDR_W      = 10;
   localparam int TIMEOUT_CYC = 100;
   localparam int NBITS       = NUM_BYTES * 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic              rx_clr_rdy;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wdata;
   logic              core_start;
   logic              core_done;
   logic [3:0]        core_digit;
   logic              tx_busy;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic [3:0]        result;
   logic              frame_err;

   always #5 clk = ~clk;

   snn_frame_loader #(
      .NUM_BYTES  (NUM_BYTES),
      .ADDR_W     (ADDR_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_rdy    (rx_rdy),
      .rx_data   (rx_data),
      .rx_clr_rdy(rx_clr_rdy),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .core_start(core_start),
      .core_done (core_done),
      .core_digit(core_digit),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .result    (result),
      .frame_err (frame_err)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   int         exp_addr[$];
   logic       exp_dat[$];
   logic [3:0] exp_dig[$];
   logic       ram_exp[NBITS];
   logic       ram_act[NBITS];
   logic [7:0] frame_bytes[NUM_BYTES];

   int         fpos = 0;
   logic [3:0] frame_digit = 4'h0;
   int         done_dly = 5;
   bit         hold_busy = 1'b0;
   int         bytes_sent = 0;
   int         exp_starts = 0;
   int         exp_ferr = 0;
   int         acc_cyc = 0;
   int         first_acc = 0;

   int n_wr = 0;
   int n_start = 0;
   int n_tx = 0;
   int n_clr = 0;
   int n_ferr = 0;
   int last_wr_cyc = -10;
   int last_tx_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   initial begin : cycle_counter
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin : monitor
      logic [3:0] d;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ram_we) begin
               n_wr++;
               chk("write_expected", exp_addr.size() > 0, 1);
               if (exp_addr.size() > 0) begin
                  chk("wr_addr", ram_addr, exp_addr.pop_front());
                  chk("wr_data", ram_wdata, exp_dat.pop_front());
               end
               if (int'(ram_addr) < NBITS) ram_act[ram_addr] = ram_wdata;
               if (int'(ram_addr) == NBITS - 1) last_wr_cyc = cyc;
            end
            if (core_start) begin
               n_start++;
               chk("start_latency", cyc - last_wr_cyc, 1);
            end
            if (tx_start) begin
               n_tx++;
               last_tx_cyc = cyc;
               chk("tx_busy_low", tx_busy, 0);
               chk("tx_expected", exp_dig.size() > 0, 1);
               if (exp_dig.size() > 0) begin
                  d = exp_dig.pop_front();
                  chk("tx_data", tx_data, {4'h3, d});
                  chk("result", result, d);
               end
            end
            if (rx_clr_rdy) begin
               n_clr++;
               chk("clr_with_rdy", rx_rdy, 1);
            end
            if (frame_err) n_ferr++;
         end
      end
   end

   // snn_core stand-in; also throws stray core_done pulses when idle.
   initial begin : core_model
      core_done  = 1'b0;
      core_digit = 4'h0;
      forever begin
         @(negedge clk);
         if (rst_n && core_start) begin
            @(posedge clk); #1;
            core_done = 1'b0;
            for (int i = 1; i < done_dly; i++) begin
               @(posedge clk); #1;
            end
            core_done  = 1'b1;
            core_digit = frame_digit;
            @(posedge clk); #1;
            core_done  = 1'b0;
         end else begin
            @(posedge clk); #1;
            core_done  = ($urandom_range(0, 30) == 0);
            core_digit = 4'($urandom);
         end
      end
   end

   initial begin : tx_model
      int busy_left;
      busy_left = 0;
      tx_busy   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && tx_start) busy_left = $urandom_range(0, 8);
         @(posedge clk); #1;
         tx_busy = hold_busy || (busy_left > 0);
         if (busy_left > 0) busy_left--;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit got;
      for (int i = 0; i < 8; i++) begin
         exp_addr.push_back(fpos * 8 + i);
         exp_dat.push_back(b[i]);
         ram_exp[fpos * 8 + i] = b[i];
      end
      fpos++;
      if (fpos == NUM_BYTES) begin
         fpos = 0;
         exp_dig.push_back(frame_digit);
         exp_starts++;
      end
      bytes_sent++;
      rx_data = b;
      rx_rdy  = 1'b1;
      got     = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
         @(negedge clk);
         if (rx_clr_rdy) got = 1'b1;
      end
      chk("byte_accepted", got, 1);
      acc_cyc = cyc;
      @(posedge clk); #1;
      rx_rdy  = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic wait_tx(input int target);
      for (int t = 0; t < 3000 && n_tx < target; t++) @(negedge clk);
      chk("tx_seen", n_tx, target);
   endtask

   task automatic check_frame();
      int errs;
      errs = 0;
      for (int a = 0; a < NBITS; a++) if (ram_act[a] !== ram_exp[a]) errs++;
      chk("frame_ram_mismatches", errs, 0);
   endtask

   task automatic run_frame(input logic [3:0] d, input int max_gap, input bit wait_res);
      int prev;
      int base_wr;
      prev        = 0;
      base_wr     = n_wr;
      frame_digit = d;
      for (int k = 0; k < NUM_BYTES; k++) begin
         send_byte(frame_bytes[k]);
         if (k == 0) first_acc = acc_cyc;
         else if (max_gap == 0) chk("b2b_interval", acc_cyc - prev, 9);
         else chk("min_interval_ok", (acc_cyc - prev) >= 9, 1);
         prev = acc_cyc;
         repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk); #1;
         end
      end
      if (wait_res) begin
         wait_tx(exp_starts);
         chk("frame_writes", n_wr - base_wr, NBITS);
         check_frame();
      end
   endtask

   task automatic reset_checks(input string tag);
      @(negedge clk);
      chk({tag, "_rx_clr_rdy"}, rx_clr_rdy, 0);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_wdata"}, ram_wdata, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_tx_start"}, tx_start, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_tx_data"}, tx_data, 8'h30);
      chk({tag, "_frame_err"}, frame_err, 0);
   endtask

   task automatic fill_random();
      for (int k = 0; k < NUM_BYTES; k++) frame_bytes[k] = 8'($urandom);
   endtask

   initial begin : stimulus
      logic [7:0] pat;
      int ones;
      int clr_before;
      int rel_cyc;
      int tx_before;
      rst_n   = 1'b0;
      rx_rdy  = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(posedge clk);
      reset_checks("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // A5 followed by zeros, digit 7 after 5 cycles
      frame_bytes[0] = 8'hA5;
      for (int k = 1; k < NUM_BYTES; k++) frame_bytes[k] = 8'h00;
      done_dly = 5;
      run_frame(4'd7, 3, 1'b1);
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) chk("t2_bit", ram_act[i], pat[i]);
      ones = 0;
      for (int a = 8; a < NBITS; a++) if (ram_act[a] !== 1'b0) ones++;
      chk("t2_upper_zero", ones, 0);
      chk("t2_starts", n_start, 1);
      chk("t2_tx_count", n_tx, 1);
      chk("t2_result", result, 7);

      // rx_rdy held high continuously: one acceptance every 9 cycles
      fill_random();
      done_dly = $urandom_range(1, 20);
      run_frame(4'($urandom), 0, 1'b1);

      // transmitter busy when the result is ready
      fill_random();
      hold_busy = 1'b1;
      tx_before = n_tx;
      run_frame(4'($urandom_range(10, 15)), 2, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      chk("tx_held_while_busy", n_tx, tx_before);
      fill_random();
      rx_data = frame_bytes[0];
      rx_rdy  = 1'b1;
      clr_before = n_clr;
      repeat (20) @(posedge clk);
      #1;
      chk("rx_held_in_send", n_clr, clr_before);
      rel_cyc   = cyc;
      hold_busy = 1'b0;
      run_frame(4'($urandom), 2, 1'b1);
      chk("tx_after_release", last_tx_cyc > rel_cyc, 1);
      chk("next_byte_after_send", first_acc > last_tx_cyc - (n_tx - tx_before - 1) * 100000, 1);

      // reset after 40 bytes of a frame
      fill_random();
      frame_digit = 4'h9;
      for (int k = 0; k < 40; k++) send_byte(frame_bytes[k]);
      repeat (12) @(posedge clk);
      #1;
      chk("partial_writes_done", exp_addr.size(), 0);
      rst_n = 1'b0;
      reset_checks("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      fpos  = 0;
      exp_addr.delete();
      exp_dat.delete();
      fill_random();
      run_frame(4'($urandom), 3, 1'b1);
      chk("starts_after_reset", n_start, exp_starts);

`ifdef LOADER_TIMEOUT_EN
      fill_random();
      for (int k = 0; k < 3; k++) send_byte(frame_bytes[k]);
      repeat (150) @(posedge clk);
      #1;
      exp_ferr++;
      chk("timeout_frame_err", n_ferr, exp_ferr);
      fpos = 0;
      chk("timeout_writes_done", exp_addr.size(), 0);
      fill_random();
      run_frame(4'($urandom), 3, 1'b1);
`endif

      for (int f = 0; f < 2; f++) begin
         fill_random();
         done_dly = $urandom_range(1, 20);
         run_frame(4'($urandom), 4, 1'b1);
      end

      repeat (10) @(posedge clk);
      #1;
      chk("total_starts", n_start, exp_starts);
      chk("total_tx", n_tx, exp_starts);
      chk("total_bytes_taken", n_clr, bytes_sent);
      chk("total_frame_err", n_ferr, exp_ferr);
      chk("write_q_drained", exp_addr.size(), 0);
      chk("tx_q_drained", exp_dig.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
